// File: rtl/str_sqrt_fx.sv
// Streaming fixed-point square root with root and remainder; BPS root bits are resolved per registered stage, and RND adds a round/saturate stage.
// Latency is ceil((RW+FW)/BPS) cycles, plus one when RND=1. Every stage uses valid/ready, and iready is combinational from oready.
module str_sqrt_fx #(
    parameter int RW  = 8,
    parameter int FW  = 4,
    parameter int BPS = 2,
    parameter int RND = 0,
    parameter int UW  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*RW-1:0]        num,
    input  logic [UW-1:0]          iuser,
    input  logic                   ilast,
    input  logic                   ivalid,
    output logic                   iready,
    output logic [RW+FW-1:0]       sqrt,
    output logic [2*(RW+FW)-1:0]   rem,
    output logic                   sat,
    output logic [UW-1:0]          ouser,
    output logic                   olast,
    output logic                   ovalid,
    input  logic                   oready
);
    localparam int TW  = RW + FW;
    localparam int RMW = 2 * TW;
    localparam int NS  = (TW + BPS - 1) / BPS;

    if (BPS < 1 || BPS > TW) begin : g_bad_bps
        $fatal(1, "str_sqrt_fx: BPS=%0d outside 1..%0d", BPS, TW);
    end

    logic [NS-1:0][RMW-1:0] st_rem;
    logic [NS-1:0][TW-1:0]  st_root;
    logic [NS-1:0][UW-1:0]  st_user;
    logic [NS-1:0]          st_last;
    logic [NS-1:0]          st_vld;
    logic [NS-1:0]          st_rdy;
    logic                   down_rdy;

    assign iready = st_rdy[0];

    for (genvar k = 0; k < NS; k++) begin : g_stg
        localparam int HI = TW - 1 - k * BPS;
        localparam int LO = (HI - BPS + 1 > 0) ? HI - BPS + 1 : 0;

        logic [RMW-1:0] rem_in, rem_d, rem_q, sub;
        logic [TW-1:0]  root_in, root_d, root_q;
        logic [UW-1:0]  user_in, user_q;
        logic           last_in, last_q, vld_in, vld_q;

        if (k == 0) begin : g_src
            assign rem_in  = RMW'(num) << (2 * FW);
            assign root_in = '0;
            assign user_in = iuser;
            assign last_in = ilast;
            assign vld_in  = ivalid;
        end else begin : g_src
            assign rem_in  = st_rem[k-1];
            assign root_in = st_root[k-1];
            assign user_in = st_user[k-1];
            assign last_in = st_last[k-1];
            assign vld_in  = st_vld[k-1];
        end

        // Restoring steps: trial subtrahend is (root + 2^b)^2 - root^2.
        always_comb begin
            rem_d  = rem_in;
            root_d = root_in;
            sub    = '0;
            for (int b = HI; b >= LO; b--) begin
                sub = (RMW'(root_d) << (b + 1)) | (RMW'(1) << (2 * b));
                if (rem_d >= sub) begin
                    rem_d     = rem_d - sub;
                    root_d[b] = 1'b1;
                end
            end
        end

        // A stage can accept when any stage from here to the output has a hole, or the sink is ready.
        assign st_rdy[k] = down_rdy | ~(&st_vld[NS-1:k]);

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= 1'b0;
                rem_q  <= '0;
                root_q <= '0;
                user_q <= '0;
                last_q <= 1'b0;
            end else if (st_rdy[k]) begin
                vld_q <= vld_in;
                if (vld_in) begin
                    rem_q  <= rem_d;
                    root_q <= root_d;
                    user_q <= user_in;
                    last_q <= last_in;
                end
            end
        end

        assign st_rem[k]  = rem_q;
        assign st_root[k] = root_q;
        assign st_user[k] = user_q;
        assign st_last[k] = last_q;
        assign st_vld[k]  = vld_q;
    end

    if (RND != 0) begin : g_rnd
        logic [TW-1:0]  r_in, sqrt_q;
        logic [RMW-1:0] rm_in, rem_q;
        logic [UW-1:0]  user_q;
        logic           up, ovf, sat_q, last_q, vld_q;

        assign r_in  = st_root[NS-1];
        assign rm_in = st_rem[NS-1];
        // N is an integer, so N > R^2 + R exactly when the root is nearer R+1.
        assign up    = rm_in > RMW'(r_in);
        assign ovf   = &r_in;
        assign down_rdy = oready | ~vld_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= 1'b0;
                sqrt_q <= '0;
                rem_q  <= '0;
                sat_q  <= 1'b0;
                user_q <= '0;
                last_q <= 1'b0;
            end else if (down_rdy) begin
                vld_q <= st_vld[NS-1];
                if (st_vld[NS-1]) begin
                    sqrt_q <= up ? (ovf ? '1 : r_in + 1'b1) : r_in;
                    sat_q  <= up & ovf;
                    rem_q  <= rm_in;
                    user_q <= st_user[NS-1];
                    last_q <= st_last[NS-1];
                end
            end
        end

        assign sqrt   = sqrt_q;
        assign rem    = rem_q;
        assign sat    = sat_q;
        assign ouser  = user_q;
        assign olast  = last_q;
        assign ovalid = vld_q;
    end else begin : g_trunc
        assign down_rdy = oready;
        assign sqrt     = st_root[NS-1];
        assign rem      = st_rem[NS-1];
        assign sat      = 1'b0;
        assign ouser    = st_user[NS-1];
        assign olast    = st_last[NS-1];
        assign ovalid   = st_vld[NS-1];
    end
endmodule
